processor_ctrl: RTL and testbench

//  Sequencer for the 8-bit R0/R1 processor datapath. Fetches instructions from program memory over
//  a req/ack handshake, decodes them and drives single-cycle strobes to the datapath.

---
 rtl/processor_ctrl.sv | 167 ++++++++++++++++
 tb/tb_processor_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/processor_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit R0/R1 datapath; owns the program counter.
// Optional feature: define PROC_CTRL_BRANCH_EN to enable JMP (8) and JZ (9); otherwise they run as NOP.
module processor_ctrl #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               prog_rd,
    output logic [ADDR_W-1:0]  prog_addr,
    input  logic               prog_ack,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               alu_zero,
    output logic               load_en,
    output logic               store_en,
    output logic               R0_ce,
    output logic               R1_ce,
    output logic               R0_oe,
    output logic               R1_oe,
    output logic [1:0]         alu_op,
    output logic [INSTR_W-5:0] imm,
    output logic [3:0]         instr_code,
    output logic               halted
);
    localparam int IMM_W = INSTR_W - 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t               state_r, state_s;
    logic [INSTR_W-1:0]   instr_r;
    logic [ADDR_W-1:0]    pc_r, pc_s;
    logic [3:0]           opcode_s;
    logic [ADDR_W-1:0]    target_s;
    logic                 prog_rd_r, halted_r;
    logic                 load_en_r, store_en_r, r0_ce_r, r1_ce_r, r0_oe_r, r1_oe_r;
    logic                 load_en_s, store_en_s, r0_ce_s, r1_ce_s, r0_oe_s, r1_oe_s;
    logic [1:0]           alu_op_r, alu_op_s;

    assign opcode_s = instr_r[INSTR_W-1:INSTR_W-4];
    assign target_s = ADDR_W'(instr_r[IMM_W-1:0]);

`ifndef PROC_CTRL_BRANCH_EN
    logic unused_alu_zero_s;
    assign unused_alu_zero_s = alu_zero;
`endif

    // Next-state selection
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (run) state_s = S_FETCH;
                else     state_s = S_IDLE;
            end
            S_FETCH: begin
                if (prog_ack) state_s = S_DECODE;
                else          state_s = S_FETCH;
            end
            S_DECODE: state_s = S_EXEC;
            S_EXEC: begin
                if (opcode_s == 4'hF) state_s = S_HALT;
                else                  state_s = S_FETCH;
            end
            S_HALT:  state_s = S_HALT;
            default: state_s = S_IDLE;
        endcase
    end

    // Program counter advance; HALT leaves the PC on the halting instruction
    always_comb begin
        pc_s = pc_r;
        if (state_r == S_EXEC) begin
            if (opcode_s == 4'hF) begin
                pc_s = pc_r;
            end
`ifdef PROC_CTRL_BRANCH_EN
            else if ((opcode_s == 4'h8) || ((opcode_s == 4'h9) && alu_zero)) begin
                pc_s = target_s;
            end
`endif
            else begin
                pc_s = pc_r + ADDR_W'(1);
            end
        end else begin
            pc_s = pc_r;
        end
    end

    // Strobes are computed during DECODE so the registered copies are high only in EXEC
    always_comb begin
        load_en_s  = 1'b0;
        store_en_s = 1'b0;
        r0_ce_s    = 1'b0;
        r1_ce_s    = 1'b0;
        r0_oe_s    = 1'b0;
        r1_oe_s    = 1'b0;
        alu_op_s   = 2'b00;
        if (state_r == S_DECODE) begin
            case (opcode_s)
                4'h1: begin load_en_s  = 1'b1; r0_ce_s = 1'b1; end
                4'h2: begin load_en_s  = 1'b1; r1_ce_s = 1'b1; end
                4'h3: begin store_en_s = 1'b1; r0_oe_s = 1'b1; end
                4'h4: begin store_en_s = 1'b1; r1_oe_s = 1'b1; end
                4'h5: begin r0_oe_s    = 1'b1; r1_ce_s = 1'b1; end
                4'h6: begin r0_ce_s    = 1'b1; alu_op_s = 2'b01; end
                4'h7: begin r0_ce_s    = 1'b1; alu_op_s = 2'b10; end
                default: begin
                    load_en_s = 1'b0;
                end
            endcase
        end else begin
            load_en_s = 1'b0;
        end
    end

    // State, PC, instruction latch and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            pc_r       <= '0;
            instr_r    <= '0;
            prog_rd_r  <= 1'b0;
            halted_r   <= 1'b0;
            load_en_r  <= 1'b0;
            store_en_r <= 1'b0;
            r0_ce_r    <= 1'b0;
            r1_ce_r    <= 1'b0;
            r0_oe_r    <= 1'b0;
            r1_oe_r    <= 1'b0;
            alu_op_r   <= 2'b00;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            if ((state_r == S_FETCH) && prog_ack) instr_r <= prog_data;
            else                                  instr_r <= instr_r;
            prog_rd_r  <= (state_s == S_FETCH);
            halted_r   <= (state_s == S_HALT);
            load_en_r  <= load_en_s;
            store_en_r <= store_en_s;
            r0_ce_r    <= r0_ce_s;
            r1_ce_r    <= r1_ce_s;
            r0_oe_r    <= r0_oe_s;
            r1_oe_r    <= r1_oe_s;
            alu_op_r   <= alu_op_s;
        end
    end

    assign prog_rd    = prog_rd_r;
    assign prog_addr  = pc_r;
    assign load_en    = load_en_r;
    assign store_en   = store_en_r;
    assign R0_ce      = r0_ce_r;
    assign R1_ce      = r1_ce_r;
    assign R0_oe      = r0_oe_r;
    assign R1_oe      = r1_oe_r;
    assign alu_op     = alu_op_r;
    assign imm        = instr_r[IMM_W-1:0];
    assign instr_code = opcode_s;
    assign halted     = halted_r;
endmodule

// File: tb/tb_processor_ctrl.sv
// Directed table-driven bench for processor_ctrl with a program-memory responder model.
module tb_processor_ctrl;
    logic       clk = 1'b0;
    logic       rst, run, prog_rd, prog_ack, alu_zero;
    logic [4:0] prog_addr;
    logic [7:0] prog_data;
    logic       load_en, store_en, R0_ce, R1_ce, R0_oe, R1_oe, halted;
    logic [1:0] alu_op;
    logic [3:0] imm, instr_code;

    processor_ctrl #(.ADDR_W(5), .INSTR_W(8)) dut (
        .clk(clk), .rst(rst), .run(run), .prog_rd(prog_rd), .prog_addr(prog_addr),
        .prog_ack(prog_ack), .prog_data(prog_data), .alu_zero(alu_zero),
        .load_en(load_en), .store_en(store_en), .R0_ce(R0_ce), .R1_ce(R1_ce),
        .R0_oe(R0_oe), .R1_oe(R1_oe), .alu_op(alu_op), .imm(imm),
        .instr_code(instr_code), .halted(halted)
    );

    always #5 clk = ~clk;

`ifdef PROC_CTRL_BRANCH_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    typedef struct {
        logic [7:0] instr;
        logic       zero;
        logic [7:0] strb;
        logic [4:0] next_addr;
        logic       halt;
    } vec_t;

    vec_t       vecs [17];
    logic [7:0] mem [32];
    int         wait_cycles = 0;
    int         rd_cnt = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    // Program memory: acks after wait_cycles cycles of prog_rd, sampled on the falling edge
    initial begin
        prog_ack  = 1'b0;
        prog_data = 8'h00;
        forever begin
            @(negedge clk);
            if (prog_rd === 1'b1) begin
                if (rd_cnt >= wait_cycles) begin
                    prog_ack  = 1'b1;
                    prog_data = mem[prog_addr];
                end else begin
                    prog_ack = 1'b0;
                end
                rd_cnt = rd_cnt + 1;
            end else begin
                prog_ack = 1'b0;
                rd_cnt   = 0;
            end
        end
    end

    function automatic logic [7:0] strobes();
        return {load_en, store_en, R0_ce, R1_ce, R0_oe, R1_oe, alu_op};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        run      = 1'b0;
        alu_zero = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int a = 0; a < 32; a++) mem[a] = v;
    endtask

    initial begin
        int rd_high;
        logic [7:0] exp_s;
        rst = 1'b1; run = 1'b0; alu_zero = 1'b0;
        fill_mem(8'h00);

        vecs[0]  = '{8'h00, 1'b0, 8'h00, 5'd1, 1'b0};
        vecs[1]  = '{8'h15, 1'b0, 8'hA0, 5'd1, 1'b0};
        vecs[2]  = '{8'h23, 1'b0, 8'h90, 5'd1, 1'b0};
        vecs[3]  = '{8'h3A, 1'b0, 8'h48, 5'd1, 1'b0};
        vecs[4]  = '{8'h41, 1'b0, 8'h44, 5'd1, 1'b0};
        vecs[5]  = '{8'h50, 1'b0, 8'h18, 5'd1, 1'b0};
        vecs[6]  = '{8'h60, 1'b0, 8'h21, 5'd1, 1'b0};
        vecs[7]  = '{8'h70, 1'b1, 8'h22, 5'd1, 1'b0};
        vecs[8]  = '{8'h84, 1'b0, 8'h00, (BR ? 5'd4 : 5'd1), 1'b0};
        vecs[9]  = '{8'h97, 1'b0, 8'h00, 5'd1, 1'b0};
        vecs[10] = '{8'h97, 1'b1, 8'h00, (BR ? 5'd7 : 5'd1), 1'b0};
        vecs[11] = '{8'hA5, 1'b1, 8'h00, 5'd1, 1'b0};
        vecs[12] = '{8'hB6, 1'b0, 8'h00, 5'd1, 1'b0};
        vecs[13] = '{8'hC7, 1'b0, 8'h00, 5'd1, 1'b0};
        vecs[14] = '{8'hD8, 1'b1, 8'h00, 5'd1, 1'b0};
        vecs[15] = '{8'hE9, 1'b0, 8'h00, 5'd1, 1'b0};
        vecs[16] = '{8'hF3, 1'b0, 8'h00, 5'd0, 1'b1};

        // Reset state
        do_reset();
        check("rst_strobes", {24'd0, strobes()}, 32'd0);
        check("rst_prog_rd", {31'd0, prog_rd}, 32'd0);
        check("rst_addr", {27'd0, prog_addr}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_code_imm", {24'd0, instr_code, imm}, 32'd0);

        // Opcode table: one instruction at address 0
        for (int i = 0; i < 17; i++) begin
            do_reset();
            fill_mem(8'h00);
            mem[0]   = vecs[i].instr;
            alu_zero = vecs[i].zero;
            run      = 1'b1;
            step();
            check("vec_fetch_rd", {31'd0, prog_rd}, 32'd1);
            check("vec_fetch_addr", {27'd0, prog_addr}, 32'd0);
            step();
            check("vec_decode_code_imm", {24'd0, instr_code, imm}, {24'd0, vecs[i].instr});
            check("vec_decode_strobes", {24'd0, strobes()}, 32'd0);
            step();
            check("vec_exec_strobes", {24'd0, strobes()}, {24'd0, vecs[i].strb});
            check("vec_excl_oe", {31'd0, R0_oe & R1_oe}, 32'd0);
            check("vec_excl_ld_st", {31'd0, load_en & store_en}, 32'd0);
            step();
            check("vec_next_addr", {27'd0, prog_addr}, {27'd0, vecs[i].next_addr});
            check("vec_halted", {31'd0, halted}, {31'd0, vecs[i].halt});
            check("vec_post_strobes", {24'd0, strobes()}, 32'd0);
        end

        // Asynchronous reset in the middle of a stalled fetch at address 1
        do_reset();
        fill_mem(8'h00);
        run = 1'b1;
        step();
        step();
        wait_cycles = 10;
        step();
        step();
        check("midrst_pre_rd", {31'd0, prog_rd}, 32'd1);
        check("midrst_pre_addr", {27'd0, prog_addr}, 32'd1);
        step();
        rst = 1'b1;
        #1;
        check("midrst_rd", {31'd0, prog_rd}, 32'd0);
        check("midrst_addr", {27'd0, prog_addr}, 32'd0);
        check("midrst_strobes", {24'd0, strobes()}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_cycles = 0;
        step();
        check("midrst_restart_rd", {31'd0, prog_rd}, 32'd1);
        check("midrst_restart_addr", {27'd0, prog_addr}, 32'd0);

        // Four-instruction program, zero-wait acks, strobe timing by cycle
        do_reset();
        fill_mem(8'h00);
        mem[0] = 8'h15; mem[1] = 8'h23; mem[2] = 8'h60; mem[3] = 8'hF0;
        run = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            case (c)
                3:       exp_s = 8'hA0;
                6:       exp_s = 8'h90;
                9:       exp_s = 8'h21;
                default: exp_s = 8'h00;
            endcase
            check($sformatf("prog_cycle%0d_strobes", c), {24'd0, strobes()}, {24'd0, exp_s});
        end
        check("prog_halted", {31'd0, halted}, 32'd1);
        check("prog_halt_addr", {27'd0, prog_addr}, 32'd3);
        check("prog_halt_rd", {31'd0, prog_rd}, 32'd0);

        // Wait states: ack after 4 extra cycles
        do_reset();
        fill_mem(8'h00);
        mem[0] = 8'h15;
        wait_cycles = 4;
        run = 1'b1;
        rd_high = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (prog_rd !== 1'b1) break;
            rd_high++;
            check("wait_addr_stable", {27'd0, prog_addr}, 32'd0);
            check("wait_no_strobe", {24'd0, strobes()}, 32'd0);
        end
        check("wait_rd_cycles", rd_high, 32'd5);
        check("wait_decode_strobes", {24'd0, strobes()}, 32'd0);
        step();
        check("wait_exec_strobes", {24'd0, strobes()}, 32'h000000A0);
        wait_cycles = 0;

        // PC wrap over 33 NOPs
        do_reset();
        fill_mem(8'h00);
        run = 1'b1;
        for (int i = 0; i < 33; i++) begin
            step();
            check("wrap_addr", {27'd0, prog_addr}, i % 32);
            step();
            step();
            check("wrap_exec_strobes", {24'd0, strobes()}, 32'd0);
        end
        step();
        check("wrap_halted", {31'd0, halted}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
